// File: rtl/multicycle_control.sv
// Main controller for the multi-cycle 32-bit datapath.
// It is a Moore FSM that steps each instruction through fetch, decode,
// execute, memory and writeback, and it decodes the ALU operation.
// Holding reset high forces every output to zero.
`timescale 1ns/1ps

module multicycle_control #(
  parameter int STATE_W = 4,
  parameter bit ADDI_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUop,
  output logic               illegalOp,
  output logic [STATE_W-1:0] stateOut
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q, state_d;

  // The controller never uses the zero flag itself. Whoever consumes
  // PCWriteCond gates it with zero, so the flag is only tied off here.
  logic zeroUnused;
  assign zeroUnused = zero;

  logic       opLegal;
  logic       functLegal;
  logic [2:0] functAluOp;

  // State register. A synchronous reset sends the FSM back to FETCH, which
  // abandons any instruction that is in progress.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Decode the opcode and funct fields that the DECODE and EXEC states use.
  always_comb begin
    opLegal    = 1'b0;
    functLegal = 1'b1;
    functAluOp = 3'b010;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: opLegal = 1'b1;
      OP_ADDI:                              opLegal = ADDI_EN;
      default:                              opLegal = 1'b0;
    endcase
    case (funct)
      6'b100000: functAluOp = 3'b010;
      6'b100010: functAluOp = 3'b110;
      6'b100100: functAluOp = 3'b000;
      6'b100101: functAluOp = 3'b001;
      6'b101010: functAluOp = 3'b111;
      default:   functLegal = 1'b0;
    endcase
  end

  // Next-state logic. Only DECODE and MEMADR look at the opcode.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EN ? ADDIEX : FETCH;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = RWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs come from the registered state. Reset overrides all of them, so
  // no write enable can fire while reset is high.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUop       = 3'b000;
    illegalOp   = 1'b0;
    stateOut    = '0;
    if (!reset) begin
      stateOut[3:0] = state_q;
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
          ALUop   = 3'b010;
        end
        DECODE: begin
          ALUSrcB   = 2'b11;
          ALUop     = 3'b010;
          illegalOp = ~opLegal;
        end
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUop   = 3'b010;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA   = 1'b1;
          ALUop     = functAluOp;
          illegalOp = ~functLegal;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUop       = 3'b110;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard testbench for multicycle_control.
// Each stimulus step queues the output vector expected in that cycle. A
// monitor pops the queue on every falling edge and compares it with the DUT
// outputs. The monitor also checks the exclusivity rules on every cycle.
`timescale 1ns/1ps

module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUop;
  logic [3:0] stateOut;

  typedef struct {
    logic [21:0] v;
    string       nm;
  } exp_t;

  exp_t expQ[$];
  int   testsRun  = 0;
  int   failCount = 0;

  localparam int RST = 99;

  multicycle_control #(.STATE_W(4), .ADDI_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .illegalOp(illegalOp), .stateOut(stateOut)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packs the outputs in the same order the monitor uses:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUop,illegalOp,stateOut}.
  function automatic logic [21:0] vec(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rd,
    input logic rw, input logic srca, input logic [1:0] srcb,
    input logic [1:0] pcs, input logic [2:0] aop, input logic ill,
    input logic [3:0] st);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, srcb, pcs, aop, ill, st};
  endfunction

  // Hand-written expected outputs for each state. aop and ill matter only
  // where the state's outputs depend on the decoded instruction fields.
  function automatic logic [21:0] expState(input int st, input logic [2:0] aop, input logic ill);
    case (st)
      0:  return vec(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b010,0,4'd0);
      1:  return vec(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,ill,4'd1);
      2:  return vec(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,4'd2);
      3:  return vec(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,4'd3);
      4:  return vec(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,4'd4);
      5:  return vec(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,4'd5);
      6:  return vec(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,aop,ill,4'd6);
      7:  return vec(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,4'd7);
      8:  return vec(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,4'd8);
      9:  return vec(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,4'd9);
      10: return vec(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,4'd10);
      11: return vec(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,4'd11);
      default: return 22'h0;
    endcase
  endfunction

  // Moves one cycle forward, sets reset for that cycle and queues the
  // vector the monitor should see.
  task automatic applyStimulus(input logic rst, input int st, input logic [2:0] aop,
                               input logic ill, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    e.v   = expState(st, aop, ill);
    e.nm  = nm;
    expQ.push_back(e);
  endtask

  // Starts a new instruction: loads the instruction fields and queues the
  // FETCH cycle.
  task automatic startInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    opcode = op;
    funct  = fn;
    zero   = z;
    e.v    = expState(0, 3'b000, 1'b0);
    e.nm   = {nm, "_fetch"};
    expQ.push_back(e);
  endtask

  // Scoreboard check for one queued vector.
  task automatic checkOutput(input exp_t e);
    logic [21:0] act;
    act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop, illegalOp, stateOut};
    testsRun++;
    if (act !== e.v) begin
      failCount++;
      $display("[TB] FAIL %s: got %06h, expected %06h", e.nm, act, e.v);
    end
  endtask

  // Monitor: on every falling edge, check the invariants and pop any queued expectation.
  always @(negedge clk) begin
    exp_t e;
    testsRun++;
    if (MemRead === 1'b1 && MemWrite === 1'b1) begin
      failCount++;
      $display("[TB] FAIL memExcl: MemRead=%b MemWrite=%b, required not both 1", MemRead, MemWrite);
    end
    testsRun++;
    if (RegWrite === 1'b1 && PCWrite === 1'b1) begin
      failCount++;
      $display("[TB] FAIL wrExcl: RegWrite=%b PCWrite=%b, required not both 1", RegWrite, PCWrite);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [5:0] fn;
    logic [2:0] aop;
  } rt_t;

  // Directed sequences first, then a random instruction stream.
  initial begin
    rt_t rt[4];
    int  done;
    int  cycles;
    reset  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;

    applyStimulus(1, RST, 3'b000, 0, "reset0");
    applyStimulus(1, RST, 3'b000, 0, "reset1");

    startInstr(6'b000000, 6'b101010, 0, "slt");
    applyStimulus(0, 1, 3'b000, 0, "slt_decode");
    applyStimulus(0, 6, 3'b111, 0, "slt_exec");
    applyStimulus(0, 7, 3'b000, 0, "slt_rwb");

    rt[0] = '{6'b100000, 3'b010};
    rt[1] = '{6'b100010, 3'b110};
    rt[2] = '{6'b100100, 3'b000};
    rt[3] = '{6'b100101, 3'b001};
    for (int i = 0; i < 4; i++) begin
      startInstr(6'b000000, rt[i].fn, 0, "rtype");
      applyStimulus(0, 1, 3'b000, 0, "rtype_decode");
      applyStimulus(0, 6, rt[i].aop, 0, "rtype_exec");
      applyStimulus(0, 7, 3'b000, 0, "rtype_rwb");
    end

    startInstr(6'b100011, 6'b000000, 0, "lw");
    applyStimulus(0, 1, 3'b000, 0, "lw_decode");
    applyStimulus(0, 2, 3'b000, 0, "lw_memadr");
    applyStimulus(0, 3, 3'b000, 0, "lw_memrd");
    applyStimulus(0, 4, 3'b000, 0, "lw_memwb");

    startInstr(6'b101011, 6'b000000, 0, "sw");
    applyStimulus(0, 1, 3'b000, 0, "sw_decode");
    applyStimulus(0, 2, 3'b000, 0, "sw_memadr");
    applyStimulus(0, 5, 3'b000, 0, "sw_memwr");

    startInstr(6'b000100, 6'b000000, 1, "beqTaken");
    applyStimulus(0, 1, 3'b000, 0, "beqTaken_decode");
    applyStimulus(0, 8, 3'b000, 0, "beqTaken_branch");
    startInstr(6'b000100, 6'b000000, 0, "beqNotTaken");
    applyStimulus(0, 1, 3'b000, 0, "beqNotTaken_decode");
    applyStimulus(0, 8, 3'b000, 0, "beqNotTaken_branch");

    startInstr(6'b000010, 6'b000000, 0, "jump");
    applyStimulus(0, 1, 3'b000, 0, "jump_decode");
    applyStimulus(0, 9, 3'b000, 0, "jump_jump");

    startInstr(6'b001000, 6'b000000, 0, "addi");
    applyStimulus(0, 1, 3'b000, 0, "addi_decode");
    applyStimulus(0, 10, 3'b000, 0, "addi_exec");
    applyStimulus(0, 11, 3'b000, 0, "addi_wb");

    startInstr(6'b111111, 6'b000000, 0, "illOp");
    applyStimulus(0, 1, 3'b000, 1, "illOp_decode");

    startInstr(6'b000000, 6'b000111, 0, "illFunct");
    applyStimulus(0, 1, 3'b000, 0, "illFunct_decode");
    applyStimulus(0, 6, 3'b010, 1, "illFunct_exec");
    applyStimulus(0, 7, 3'b000, 0, "illFunct_rwb");

    startInstr(6'b100011, 6'b000000, 0, "lwAbort");
    applyStimulus(0, 1, 3'b000, 0, "lwAbort_decode");
    applyStimulus(0, 2, 3'b000, 0, "lwAbort_memadr");
    applyStimulus(0, 3, 3'b000, 0, "lwAbort_memrd");
    applyStimulus(1, RST, 3'b000, 0, "lwAbort_reset");
    startInstr(6'b000010, 6'b000000, 0, "afterAbort");
    applyStimulus(0, 1, 3'b000, 0, "afterAbort_decode");
    applyStimulus(0, 9, 3'b000, 0, "afterAbort_jump");

    // Random stream. A new instruction is loaded whenever the DUT is back in
    // FETCH, and the monitor keeps checking the invariants.
    done   = 0;
    cycles = 0;
    while (done < 1000 && cycles < 20000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (stateOut == 4'd0) begin
        case ($urandom_range(0, 7))
          0: opcode = 6'b000000;
          1: opcode = 6'b100011;
          2: opcode = 6'b101011;
          3: opcode = 6'b000100;
          4: opcode = 6'b000010;
          5: opcode = 6'b001000;
          6: opcode = 6'b111111;
          default: opcode = 6'($urandom_range(0, 63));
        endcase
        funct = 6'($urandom_range(0, 63));
        zero  = 1'($urandom_range(0, 1));
        done++;
      end
    end
    testsRun++;
    if (done < 1000) begin
      failCount++;
      $display("[TB] FAIL randomStream: got %0d instructions, required 1000 within cycle budget", done);
    end

    @(negedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL queueDrain: got %0d pending, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
